// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the register-file hazard scoreboard and its write-port arbiter.
package regfile_scoreboard_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] RegIdx;

  typedef struct packed {
    logic        valid;
    RegIdx       rd;
    logic [31:0] data;
  } WbReq;

endpackage

// File: rtl/regfile_scoreboard_wb_arbiter.sv
// Fixed-priority merge of ALU and load write-backs onto the single registered write port.
module regfile_scoreboard_wb_arbiter
  import regfile_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        ld_valid_i,
  input  logic [4:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  output logic        wback_o,
  output logic [4:0]  wreg_o,
  output logic [31:0] wdata_o
);

  // Handshake: ALU results cannot be back-pressured, so the ALU always wins.
  // A load transfers in the cycle where ld_valid_i & ld_ready_o; until then the
  // load unit holds rd/data stable.
  WbReq sel_d;
  WbReq port_q;

  assign ld_ready_o = ld_valid_i & ~alu_valid_i;

  always_comb begin
    sel_d = '0;
    if (alu_valid_i) begin
      sel_d.valid = 1'b1;
      sel_d.rd    = alu_rd_i;
      sel_d.data  = alu_data_i;
    end else if (ld_valid_i) begin
      sel_d.valid = 1'b1;
      sel_d.rd    = ld_rd_i;
      sel_d.data  = ld_data_i;
    end
  end

  // Index and data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q <= '0;
    end else begin
      port_q.valid <= sel_d.valid;
      if (sel_d.valid) begin
        port_q.rd   <= sel_d.rd;
        port_q.data <= sel_d.data;
      end
    end
  end

  assign wback_o = port_q.valid;
  assign wreg_o  = port_q.rd;
  assign wdata_o = port_q.data;

endmodule

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters, RAW/WAW issue stall, and write-port arbitration.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_stall,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  input  logic        ld_wb_valid,
  input  logic [4:0]  ld_wb_rd,
  input  logic [31:0] ld_wb_data,
  output logic        ld_wb_ready,
  output logic        o_wback,
  output logic [4:0]  o_wreg,
  output logic [31:0] o_wdata,
  output logic        o_err,
  output logic [31:0] o_stall_cnt
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0]   pend_q [NUM_REGS];
  logic                err_q;
  logic [31:0]         stall_cnt_q;
  logic                rs1_blocked;
  logic                rs2_blocked;
  logic                waw_cap;
  logic                fire;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                retire_zero;

  regfile_scoreboard_wb_arbiter u_wb_arbiter (
    .clk         (clk),
    .rst         (rst),
    .alu_valid_i (alu_wb_valid),
    .alu_rd_i    (alu_wb_rd),
    .alu_data_i  (alu_wb_data),
    .ld_valid_i  (ld_wb_valid),
    .ld_rd_i     (ld_wb_rd),
    .ld_data_i   (ld_wb_data),
    .ld_ready_o  (ld_wb_ready),
    .wback_o     (o_wback),
    .wreg_o      (o_wreg),
    .wdata_o     (o_wdata)
  );

  // A source whose last outstanding write is on the port this cycle is served by the bypass.
  assign rs1_blocked = issue_use_rs1 && (issue_rs1 != '0) && (pend_q[issue_rs1] != '0) &&
                       !(o_wback && (o_wreg == issue_rs1) && (pend_q[issue_rs1] == PEND_ONE));
  assign rs2_blocked = issue_use_rs2 && (issue_rs2 != '0) && (pend_q[issue_rs2] != '0) &&
                       !(o_wback && (o_wreg == issue_rs2) && (pend_q[issue_rs2] == PEND_ONE));
  assign waw_cap     = issue_wr && (issue_rd != '0) && (pend_q[issue_rd] == PEND_MAX);

  assign issue_stall = rst | (issue_valid & (rs1_blocked | rs2_blocked | waw_cap));
  assign fire        = issue_valid & ~issue_stall;
  assign retire_zero = o_wback && (o_wreg != '0) && (pend_q[o_wreg] == '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (fire && issue_wr && (issue_rd != '0)) inc_vec[issue_rd] = 1'b1;
    if (o_wback && (o_wreg != '0))            dec_vec[o_wreg]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pend_q[0] <= '0;
      // Retiring a zero count saturates at zero; the error flag records it.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          pend_q[i] <= pend_q[i] + PEND_ONE;
        end else if (dec_vec[i] && !inc_vec[i] && (pend_q[i] != '0)) begin
          pend_q[i] <= pend_q[i] - PEND_ONE;
        end
      end
      if (retire_zero) err_q <= 1'b1;
      if (issue_valid && issue_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_err       = err_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: a per-cycle write-port scoreboard plus scenario tasks with inline checks.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic [4:0]  issue_rd;
  logic        issue_wr;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        ld_wb_valid;
  logic [4:0]  ld_wb_rd;
  logic [31:0] ld_wb_data;
  logic        ld_wb_ready;
  logic        o_wback;
  logic [4:0]  o_wreg;
  logic [31:0] o_wdata;
  logic        o_err;
  logic [31:0] o_stall_cnt;

  int          checks;
  int          errors;
  logic [31:0] exp_stall_cnt;
  logic [37:0] exp_q[$];

  regfile_scoreboard #(.PEND_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rd      (issue_rd),
    .issue_wr      (issue_wr),
    .issue_stall   (issue_stall),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_rd     (alu_wb_rd),
    .alu_wb_data   (alu_wb_data),
    .ld_wb_valid   (ld_wb_valid),
    .ld_wb_rd      (ld_wb_rd),
    .ld_wb_data    (ld_wb_data),
    .ld_wb_ready   (ld_wb_ready),
    .o_wback       (o_wback),
    .o_wreg        (o_wreg),
    .o_wdata       (o_wdata),
    .o_err         (o_err),
    .o_stall_cnt   (o_stall_cnt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_issue();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_rd = 0; issue_wr = 0;
  endtask

  task automatic clear_wb();
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    ld_wb_valid = 0; ld_wb_rd = 0; ld_wb_data = 0;
  endtask

  task automatic drive_issue(input bit wr, input logic [4:0] rd, input bit u1,
                             input logic [4:0] rs1, input bit u2, input logic [4:0] rs2);
    issue_valid = 1; issue_wr = wr; issue_rd = rd;
    issue_use_rs1 = u1; issue_rs1 = rs1; issue_use_rs2 = u2; issue_rs2 = rs2;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_wb_valid = 1; alu_wb_rd = rd; alu_wb_data = data;
  endtask

  // One clock: push the expected next port value from the current inputs,
  // advance, then pop and compare against what the port shows.
  task automatic step(input bit exp_stall);
    logic [37:0] e;
    if (rst)               exp_q.push_back('0);
    else if (alu_wb_valid) exp_q.push_back({1'b1, alu_wb_rd, alu_wb_data});
    else if (ld_wb_valid)  exp_q.push_back({1'b1, ld_wb_rd, ld_wb_data});
    else                   exp_q.push_back('0);
    if (rst) exp_stall_cnt = '0;
    else if (issue_valid && exp_stall) exp_stall_cnt = exp_stall_cnt + 32'd1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (e[37]) begin
      if (o_wback !== 1'b1 || o_wreg !== e[36:32] || o_wdata !== e[31:0]) begin
        errors++;
        $display("FAIL port: got wback=%0b reg=%0d data=%08h expected wback=1 reg=%0d data=%08h",
                 o_wback, o_wreg, o_wdata, e[36:32], e[31:0]);
      end
    end else if (o_wback !== 1'b0) begin
      errors++;
      $display("FAIL port_idle: got wback=%0b expected 0", o_wback);
    end
  endtask

  task automatic test_reset();
    rst = 1; clear_issue(); clear_wb();
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %0b expected 1", issue_stall); end
    step(0);
    step(0);
    rst = 0;
    #1;
    checks++;
    if (o_wreg !== 5'd0 || o_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_port: got reg=%0d data=%08h expected 0/0", o_wreg, o_wdata);
    end
    checks++;
    if (o_err !== 1'b0 || o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_err_cnt: got err=%0b cnt=%0d expected 0/0", o_err, o_stall_cnt);
    end
    checks++;
    if (issue_stall !== 1'b0 || ld_wb_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got stall=%0b ld_ready=%0b expected 0/0", issue_stall, ld_wb_ready);
    end
  endtask

  task automatic test_raw();
    drive_issue(1, 5'd5, 0, 5'd0, 0, 5'd0);
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_producer: got %0b expected 0", issue_stall); end
    step(0);
    drive_issue(0, 5'd0, 1, 5'd5, 0, 5'd0);
    #1; checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b expected 1", issue_stall); end
    step(1);
    drive_alu(5'd5, 32'h0000_00A5);
    #1; checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_wb: got %0b expected 1", issue_stall); end
    step(1);
    clear_wb();
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_bypass: got %0b expected 0", issue_stall); end
    step(0);
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_pend_zero: got %0b expected 0", issue_stall); end
    step(0);
    clear_issue();
  endtask

  task automatic test_arbitration();
    drive_issue(1, 5'd3, 0, 5'd0, 0, 5'd0); step(0);
    drive_issue(1, 5'd4, 0, 5'd0, 0, 5'd0); step(0);
    clear_issue();
    drive_alu(5'd3, 32'h11);
    ld_wb_valid = 1; ld_wb_rd = 5'd4; ld_wb_data = 32'h22;
    #1; checks++;
    if (ld_wb_ready !== 1'b0) begin errors++; $display("FAIL arb_conflict: got ld_ready=%0b expected 0", ld_wb_ready); end
    step(0);
    alu_wb_valid = 0;
    #1; checks++;
    if (ld_wb_ready !== 1'b1) begin errors++; $display("FAIL arb_load: got ld_ready=%0b expected 1", ld_wb_ready); end
    step(0);
    clear_wb();
    step(0);
  endtask

  task automatic test_waw_cap();
    for (int k = 0; k < 3; k++) begin
      drive_issue(1, 5'd7, 0, 5'd0, 0, 5'd0);
      #1; checks++;
      if (issue_stall !== 1'b0) begin errors++; $display("FAIL waw_fill%0d: got %0b expected 0", k, issue_stall); end
      step(0);
    end
    #1; checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL waw_cap: got %0b expected 1", issue_stall); end
    step(1);
    drive_alu(5'd7, 32'h7777_0001);
    step(1);
    clear_wb();
    #1; checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL waw_retire_cycle: got %0b expected 1", issue_stall); end
    step(1);
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL waw_release: got %0b expected 0", issue_stall); end
    step(0);
    clear_issue();
    for (int k = 0; k < 3; k++) begin
      drive_alu(5'd7, 32'h7777_0010 + k);
      step(0);
    end
    clear_wb();
    step(0);
  endtask

  task automatic test_same_cycle();
    drive_issue(1, 5'd9, 0, 5'd0, 0, 5'd0); step(0);
    clear_issue();
    drive_alu(5'd9, 32'h9999_0001); step(0);
    clear_wb();
    drive_issue(1, 5'd9, 0, 5'd0, 0, 5'd0);
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL same_issue: got %0b expected 0", issue_stall); end
    step(0);
    drive_issue(0, 5'd0, 0, 5'd0, 1, 5'd9);
    #1; checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL same_reader: got %0b expected 1", issue_stall); end
    step(1);
    drive_alu(5'd9, 32'h9999_0002); step(1);
    clear_wb();
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL same_drain: got %0b expected 0", issue_stall); end
    step(0);
    clear_issue();
    step(0);
  endtask

  task automatic test_back_to_back();
    int ai;
    int li;
    bit alu_v;
    bit accepted;
    ai = 0; li = 0;
    for (int r = 13; r <= 18; r++) begin
      drive_issue(1, 5'(r), 0, 5'd0, 0, 5'd0);
      step(0);
    end
    clear_issue();
    for (int c = 0; c < 40 && (ai < 3 || li < 3); c++) begin
      alu_v = (ai < 3) && ($urandom_range(0, 1) == 1);
      alu_wb_valid = alu_v;
      if (alu_v) begin alu_wb_rd = 5'(13 + ai); alu_wb_data = $urandom; end
      if (!ld_wb_valid && li < 3) begin
        ld_wb_valid = 1; ld_wb_rd = 5'(16 + li); ld_wb_data = $urandom;
      end
      accepted = ld_wb_valid && !alu_v;
      #1; checks++;
      if (ld_wb_ready !== accepted) begin
        errors++; $display("FAIL b2b_ready: got %0b expected %0b", ld_wb_ready, accepted);
      end
      step(0);
      if (alu_v) ai++;
      if (accepted) begin li++; ld_wb_valid = 0; end
    end
    clear_wb();
    checks++;
    if (ai != 3 || li != 3) begin errors++; $display("FAIL b2b_timeout: got alu=%0d ld=%0d expected 3/3", ai, li); end
    step(0);
    step(0);
    for (int r = 13; r <= 18; r++) begin
      drive_issue(0, 5'd0, 1, 5'(r), 0, 5'd0);
      #1; checks++;
      if (issue_stall !== 1'b0) begin errors++; $display("FAIL b2b_drained x%0d: got %0b expected 0", r, issue_stall); end
      step(0);
    end
    clear_issue();
  endtask

  task automatic test_x0_err();
    drive_alu(5'd0, 32'h0000_DEAD);
    drive_issue(0, 5'd0, 1, 5'd0, 0, 5'd0);
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL x0_reader: got %0b expected 0", issue_stall); end
    step(0);
    clear_wb(); clear_issue();
    step(0);
    step(0);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL x0_no_err: got %0b expected 0", o_err); end
    ld_wb_valid = 1; ld_wb_rd = 5'd12; ld_wb_data = 32'h1234;
    #1; checks++;
    if (ld_wb_ready !== 1'b1) begin errors++; $display("FAIL err_ld_ready: got %0b expected 1", ld_wb_ready); end
    step(0);
    clear_wb();
    step(0);
    step(0);
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", o_err); end
    step(0);
    step(0);
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", o_err); end
    checks++;
    if (o_stall_cnt !== exp_stall_cnt) begin
      errors++; $display("FAIL stall_cnt: got %0d expected %0d", o_stall_cnt, exp_stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive_issue(1, 5'd5, 0, 5'd0, 0, 5'd0); step(0);
    step(0);
    clear_issue();
    rst = 1;
    #1; checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL mid_rst_stall: got %0b expected 1", issue_stall); end
    step(0);
    rst = 0;
    checks++;
    if (o_wback !== 1'b0 || o_wreg !== 5'd0 || o_wdata !== 32'd0) begin
      errors++; $display("FAIL mid_rst_port: got wback=%0b reg=%0d data=%08h expected 0", o_wback, o_wreg, o_wdata);
    end
    checks++;
    if (o_err !== 1'b0 || o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL mid_rst_err_cnt: got err=%0b cnt=%0d expected 0/0", o_err, o_stall_cnt);
    end
    drive_issue(0, 5'd0, 1, 5'd5, 0, 5'd0);
    #1; checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_reader: got %0b expected 0", issue_stall); end
    step(0);
    clear_issue();
    step(0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall_cnt = '0;
    test_reset();
    test_raw();
    test_arbitration();
    test_waw_cap();
    test_same_cycle();
    test_back_to_back();
    test_x0_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
